// File: rtl/z4_pkg.sv
// z4_pkg: shared types, constants and the reference evaluation of the z4 function
// (3-bit + 3-bit adder with carry-in, 4-bit zero-extended sum).
// Minterm layout {x6..x0}: a = x2..x0, b = x5..x3, cin = x6.
package z4_pkg;

    typedef logic [6:0] z4_in_t;
    typedef logic [3:0] z4_out_t;

    localparam int unsigned Z4_NUM_MINTERMS = 128;
    localparam z4_in_t      Z4_LAST_IDX     = 7'(Z4_NUM_MINTERMS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FLUSH
    } z4_state_e;

    function automatic z4_out_t z4_eval(input z4_in_t m);
        return {1'b0, m[2:0]} + {1'b0, m[5:3]} + {3'b000, m[6]};
    endfunction

endpackage

// File: rtl/z4_match.sv
// z4_match: combinational match test for one minterm.
//   idx    in  7 : minterm under test
//   target in  4 : required result value
//   mask   in  4 : result bits that must match (0 = don't care)
//   hit    out 1 : ((z4_eval(idx) ^ target) & mask) == 0
module z4_match
    import z4_pkg::*;
(
    input  logic [6:0] idx,
    input  logic [3:0] target,
    input  logic [3:0] mask,
    output logic       hit
);

    always_comb begin
        hit = ((z4_eval(z4_in_t'(idx)) ^ target) & mask) == 4'b0000;
    end

endmodule

// File: rtl/z4_preimage_enum.sv
// z4_preimage_enum: scans all 128 z4 input minterms and streams every minterm whose
// masked result equals the target, in ascending order, over valid/ready.
//   clk, rst (sync, active-high)
//   start, target[3:0], mask[3:0] : scan request, sampled in IDLE only
//   busy                          : scan in progress
//   out_valid/out_ready           : output handshake
//   out_minterm[6:0], out_last    : matching minterm, final-beat flag
//   done                          : one-cycle pulse at scan completion
//   count[7:0]                    : number of matches, held until the next start
module z4_preimage_enum
    import z4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] target,
    input  logic [3:0] mask,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] out_minterm,
    output logic       out_last,
    output logic       done,
    output logic [7:0] count
);

    z4_state_e state, state_nxt;

    z4_in_t     idx;
    z4_out_t    tgt_q;
    z4_out_t    msk_q;
    logic [7:0] count_q;
    logic       done_q;

    // Candidate register P: holds the newest match until the next one shows up,
    // so the final match can be tagged last once the scan is known to be over.
    logic       p_valid;
    z4_in_t     p_data;

    // Output register O drives the stream ports directly.
    logic       o_valid;
    z4_in_t     o_data;
    logic       o_last;

    logic hit;
    logic o_free;
    logic o_accept;
    logic scan_hit;
    logic stall;
    logic advance;
    logic scan_move;
    logic flush_move;
    logic load_o;
    logic scan_end;
    logic finish;

    z4_match u_match (
        .idx    (idx),
        .target (tgt_q),
        .mask   (msk_q),
        .hit    (hit)
    );

    always_comb begin
        o_accept   = o_valid && out_ready;
        o_free     = !o_valid || out_ready;
        scan_hit   = (state == ST_SCAN) && hit;
        // A second pending match with nowhere to put the first one freezes idx.
        stall      = scan_hit && p_valid && !o_free;
        advance    = (state == ST_SCAN) && !stall;
        scan_move  = scan_hit && p_valid && o_free;
        flush_move = (state == ST_FLUSH) && p_valid && o_free;
        load_o     = scan_move || flush_move;
        scan_end   = advance && (idx == Z4_LAST_IDX);
        finish     = (state == ST_FLUSH) &&
                     ((o_accept && o_last) || (!p_valid && !o_valid));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start)    state_nxt = ST_SCAN;
            ST_SCAN:  if (scan_end) state_nxt = ST_FLUSH;
            ST_FLUSH: if (finish)   state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy        = (state != ST_IDLE);
        out_valid   = o_valid;
        out_minterm = o_data;
        out_last    = o_valid && o_last;
        done        = done_q;
        count       = count_q;
    end

    // Datapath: scan index, capture registers, P/O buffers, counter
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            tgt_q   <= '0;
            msk_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            p_valid <= 1'b0;
            p_data  <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
        end else begin
            done_q <= finish;

            if ((state == ST_IDLE) && start) begin
                idx     <= '0;
                count_q <= '0;
                tgt_q   <= target;
                msk_q   <= mask;
            end

            if (advance) begin
                idx <= idx + 7'd1;
                if (hit) begin
                    count_q <= count_q + 8'd1;
                end
            end

            if (scan_hit && !stall) begin
                p_valid <= 1'b1;
                p_data  <= idx;
            end else if (flush_move) begin
                p_valid <= 1'b0;
            end

            // P is read before the write above takes effect, so O gets the older entry.
            if (load_o) begin
                o_valid <= 1'b1;
                o_data  <= p_data;
                o_last  <= flush_move;
            end else if (o_accept) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/z4_preimage_enum.md
# z4_preimage_enum

Sequential preimage enumerator for the z4 function: 3-bit + 3-bit adder with carry-in, 4-bit result. Given a target result value and a bit mask, it scans all 128 input minterms and streams every minterm whose masked result matches, in ascending order, over a valid/ready interface. It is the inverse direction of the z4 evaluator in the autosymmetry benchmark flow: it produces onset/offset minterm lists for any single output (y0..y3) or combination of outputs, feeding PLA writers and symmetry checkers.

## Interface
- No parameters. Widths are fixed by z4: 7 inputs, 4 outputs.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: begin a scan; sampled only in IDLE.
- `target` in 4: required result value; captured on an accepted start.
- `mask` in 4: result bits that must match; captured on an accepted start. Bits with mask 0 are don't-care.
- `busy` out 1: high from the cycle after an accepted start until `done`.
- `out_valid` out 1: `out_minterm` is valid.
- `out_ready` in 1: consumer accepts the beat.
- `out_minterm` out 7: matching input vector `{x6..x0}`.
- `out_last` out 1: final matching minterm of this scan.
- `done` out 1: one-cycle pulse at scan completion.
- `count` out 8: number of matches (0..128); valid from `done`, held until the next accepted start.

## Operation
- Function definition: a = {x2,x1,x0}, b = {x5,x4,x3}, cin = x6, r[3:0] = a + b + cin (zero-extended 4-bit sum).
- A minterm m matches when ((r(m) ^ target) & mask) == 0.
- States:
  - IDLE: `start` accepted → go to SCAN; idx=0; count=0; capture target and mask.
  - SCAN: evaluates minterm idx each cycle it advances. After idx=127 is evaluated → FLUSH.
  - FLUSH: drain the buffers.
  - FLUSH → IDLE: when the last beat handshakes, or immediately if there are no matches. `done` pulses on this transition.
- Buffering: candidate register P (one entry) and output register O (one entry, drives the `out_*` ports).
  - A new match is written to P. If P is already full, the old P entry moves to O with last=0.
  - P moves to O only when O is empty or O is being accepted in the same cycle.
  - At scan completion, P moves to O with last=1.
  - The scan stalls (idx holds) when a match is found while P is full and P cannot move.
- `count` increments for every match found. Width 8 bits; 128 is reachable when mask=0.
- `start` while busy is ignored. `target` and `mask` changing mid-scan have no effect.
- `rst` at any time: state → IDLE, P and O cleared. Every output resets to 0: `busy`, `out_valid`, `out_minterm`, `out_last`, `done`, `count`.

## Timing
- Start accepted in cycle 0. `busy`=1 from cycle 1. Minterm k is evaluated no earlier than cycle 1+k.
- With `out_ready` tied high, throughput is one match per cycle after the first. A full scan takes 128 cycles plus at most 2 drain cycles.
- The first `out_valid` appears one cycle after the second match is found, or at scan end if there is only one match.
- `out_valid`, `out_minterm` and `out_last` hold stable while `out_valid` is high and `out_ready` is low (AXI-stream rule). `out_valid` never depends combinationally on `out_ready`.
- `done` asserts in the cycle after the `out_last` handshake. `busy` drops in the same cycle that `done` asserts.
- `start` is accepted on the same cycle `done` is high, back-to-back.

## Structure
- Shared package `z4_pkg`:
  - `z4_in_t` (7-bit) and `z4_out_t` (4-bit) typedefs.
  - `Z4_NUM_MINTERMS` = 128.
  - Function `z4_eval(z4_in_t) → z4_out_t`, also used by the bench reference model.
- Sub-module `z4_match` (combinational): takes idx, target and mask; returns the match flag. The FSM, P/O buffers and counter stay in the top.

## Test plan
- target=0, mask=4'hF, `out_ready`=1 → a single beat 7'h00 with last=1; count=1.
- target=15, mask=4'hF → a single beat 7'h7F with last=1; count=1.
- mask=0 → 128 beats, 7'h00..7'h7F ascending, last only on 7'h7F; count=128 (8'h80).
- target=4'h8, mask=4'h8 (carry-out onset) with random `out_ready` backpressure → 64 beats, each matching `z4_eval`; stable while stalled; count=64.
- Reset asserted mid-scan while `out_valid`=1 → the next cycle shows all outputs 0 and state IDLE. A following start with target=0, mask=4'hF yields a correct single beat.
- `start` re-asserted during busy is ignored. `start` on the `done` cycle is accepted and its first beat is correct.
